dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Two-requester arbiter and access sequencer in front of the DataMemory block. Port 0 serves the pipeline MEM stage; port 1 serves a secondary master (loader/debug). Each access follows a request/acknowledge handshake. The block registers and drives the memory's Address/WriteData/MemWrite/MemRead/sh/sb/lh/lb inputs, captures ReadData, and rejects misaligned accesses.

Parameters:
FIXED_PRIORITY, 0, 0 = round-robin on ties; 1 = port 0 always wins ties
ADDR_W, 32, address width on all address ports

Ports:
Clk  in  1  clock; all state updates on rising edge
Reset  in  1  synchronous, active-high reset
Req0, Req1  in  1  access request; held with its fields stable until the matching Ack
Wr0, Wr1  in  1  1 = store, 0 = load
Size0, Size1  in  2  00 word, 01 half, 10 byte, 11 illegal
Addr0, Addr1  in  ADDR_W  byte address
WData0, WData1  in  32  store data (byte/half in low bits)
Ack0, Ack1  out  1  one-cycle completion pulse
Err0, Err1  out  1  valid with Ack; 1 = access rejected
RData0, RData1  out  32  load result, registered, held until the next Ack to that port
MemAddress  out  ADDR_W  to DataMemory Address
MemWriteData  out  32  to DataMemory WriteData
MemWrite, MemRead  out  1  to DataMemory
sh, sb, lh, lb  out  1  to DataMemory size controls
MemReadData  in  32  from DataMemory ReadData (combinational read)
Busy  out  1  high in any state other than IDLE
GrantId  out  1  port owning the current or last transaction

Behaviour:
- Reset: state IDLE; all outputs 0; LastGrant = 1, so port 0 wins the first tie.
- MemWrite is gated by ~Reset combinationally. A store whose ACCESS cycle overlaps Reset is never written.
- States: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE, at a rising edge with any Req high:
  - Pick a winner. A single requester wins. On a tie: with FIXED_PRIORITY=1, port 0 wins; otherwise the port != LastGrant wins.
  - Latch the winner's fields into the Mem* registers and set GrantId = LastGrant = winner.
  - Aligned access: go to ACCESS.
  - Misaligned access (half with Addr[0]=1, word with Addr[1:0]!=0) or Size=11: go directly to RESP with the error flag set. No Mem* strobe is asserted.
- ACCESS (exactly one cycle):
  - MemWrite = Wr, MemRead = ~Wr.
  - sh/sb asserted for stores and lh/lb for loads, per Size. Word access: all four are 0.
  - At the closing edge the memory commits the store. For loads, MemReadData is captured into RData<GrantId>. Then go to RESP.
- RESP (one cycle):
  - Ack<GrantId> = 1 and Err<GrantId> = error flag. On error, RData<GrantId> = 0.
  - All Mem strobes are 0. Next state IDLE.
- Latency: request sampled at edge N -> Ack high in the cycle after edge N+2 for a normal access, or after edge N+1 for an error.
- The earliest re-sample in IDLE is edge N+3. The requester must drop Req in its Ack cycle unless it intends a new request.
- The losing requester keeps Req high. It is served in the next IDLE arbitration with no starvation: round-robin guarantees service within 2 transactions.
- Req rising during ACCESS or RESP is ignored until IDLE. Fields may change only when Req is low or in the Ack cycle.
- Ack is never asserted for both ports in the same cycle.
- Sign/zero extension of sub-word loads belongs to DataMemory. The arbiter passes MemReadData through unmodified.
- Address wrap is not special-cased; the address is passed verbatim.
- Reset mid-transaction: the transaction is aborted, no Ack is issued, and the requester must re-request.

Test Plan:
- Req0 store word Addr0=0, WData0=FFFFFFFF; then a load byte Addr0=1 -> MemWrite=1 for exactly one cycle, Ack0 two cycles after sampling; load Ack0 with RData0 = DataMemory's lb result for address 1, Err0=0.
- Req0 and Req1 rise together, FIXED_PRIORITY=0, both loads -> port 0 acked first, then port 1. Repeat the tie -> port 1 acked first; never both Acks in the same cycle.
- Req1 load half Addr1=3 -> Ack1 one cycle after sampling, Err1=1, RData1=0, MemRead and lh never asserted.
- Req0 Size0=11 store -> Err0=1, MemWrite stays 0, memory contents unchanged (confirm by a later word load).
- Reset pulsed during ACCESS of a store word Addr=4, WData=12345678 -> no Ack, all outputs 0 next cycle, later load of Addr=4 returns the prior value.
- FIXED_PRIORITY=1, Req0 and Req1 held high continuously -> port 0 wins every tie; port 1 served only when Req0 is low at an IDLE sample.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port request/acknowledge arbiter that sequences single accesses into the
// DataMemory block, rejecting misaligned or illegal-size requests up front.
module dmem_arbiter #(
  parameter bit FIXED_PRIORITY = 1'b0,
  parameter int ADDR_W         = 32
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Req0,
  input  logic              Req1,
  input  logic              Wr0,
  input  logic              Wr1,
  input  logic [1:0]        Size0,
  input  logic [1:0]        Size1,
  input  logic [ADDR_W-1:0] Addr0,
  input  logic [ADDR_W-1:0] Addr1,
  input  logic [31:0]       WData0,
  input  logic [31:0]       WData1,
  output logic              Ack0,
  output logic              Ack1,
  output logic              Err0,
  output logic              Err1,
  output logic [31:0]       RData0,
  output logic [31:0]       RData1,
  output logic [ADDR_W-1:0] MemAddress,
  output logic [31:0]       MemWriteData,
  output logic              MemWrite,
  output logic              MemRead,
  output logic              sh,
  output logic              sb,
  output logic              lh,
  output logic              lb,
  input  logic [31:0]       MemReadData,
  output logic              Busy,
  output logic              GrantId
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t state, state_next;

  logic              wr_reg;
  logic [1:0]        size_reg;
  logic              err_flag;
  logic              last_grant;

  logic              any_req;
  logic              winner;
  logic              sel_wr;
  logic [1:0]        sel_size;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic              misaligned;
  logic              access;

  always_comb begin
    any_req = Req0 | Req1;
    if (Req0 && Req1)
      winner = FIXED_PRIORITY ? 1'b0 : ~last_grant;
    else
      winner = Req1;
    sel_wr    = winner ? Wr1    : Wr0;
    sel_size  = winner ? Size1  : Size0;
    sel_addr  = winner ? Addr1  : Addr0;
    sel_wdata = winner ? WData1 : WData0;
    // Bytes are always aligned; size 11 is rejected like a misalignment.
    misaligned = (sel_size == 2'b11) ||
                 (sel_size == 2'b01 && sel_addr[0]) ||
                 (sel_size == 2'b00 && sel_addr[1:0] != 2'b00);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (any_req) state_next = misaligned ? RESP : ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes are decoded from the state so they last exactly the ACCESS cycle;
  // MemWrite additionally drops the instant Reset rises.
  assign access   = (state == ACCESS);
  assign MemWrite = access & wr_reg & ~Reset;
  assign MemRead  = access & ~wr_reg;
  assign sh       = access &  wr_reg & (size_reg == 2'b01);
  assign sb       = access &  wr_reg & (size_reg == 2'b10);
  assign lh       = access & ~wr_reg & (size_reg == 2'b01);
  assign lb       = access & ~wr_reg & (size_reg == 2'b10);
  assign Busy     = (state != IDLE);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= IDLE;
      wr_reg       <= 1'b0;
      size_reg     <= 2'b00;
      err_flag     <= 1'b0;
      last_grant   <= 1'b1;
      GrantId      <= 1'b0;
      MemAddress   <= '0;
      MemWriteData <= '0;
      Ack0         <= 1'b0;
      Ack1         <= 1'b0;
      Err0         <= 1'b0;
      Err1         <= 1'b0;
      RData0       <= '0;
      RData1       <= '0;
    end else begin
      state <= state_next;
      Ack0  <= 1'b0;
      Ack1  <= 1'b0;
      Err0  <= 1'b0;
      Err1  <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            MemAddress   <= sel_addr;
            MemWriteData <= sel_wdata;
            wr_reg       <= sel_wr;
            size_reg     <= sel_size;
            err_flag     <= misaligned;
            GrantId      <= winner;
            last_grant   <= winner;
          end
        end
        ACCESS: begin
          if (!wr_reg) begin
            if (GrantId) RData1 <= MemReadData;
            else         RData0 <= MemReadData;
          end
        end
        RESP: begin
          // Ack is registered here, so it appears in the cycle after RESP.
          if (GrantId) begin
            Ack1 <= 1'b1;
            Err1 <= err_flag;
            if (err_flag) RData1 <= '0;
          end else begin
            Ack0 <= 1'b1;
            Err0 <= err_flag;
            if (err_flag) RData0 <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench: round-robin instance with a byte-array memory model, plus a
// fixed-priority instance fed by an address-derived read pattern.
module tb_dmem_arbiter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Req0, Req1, Wr0, Wr1;
  logic [1:0]  Size0, Size1;
  logic [31:0] Addr0, Addr1, WData0, WData1;
  logic        Ack0, Ack1, Err0, Err1;
  logic [31:0] RData0, RData1, MemAddress, MemWriteData, MemReadData;
  logic        MemWrite, MemRead, sh, sb, lh, lb, Busy, GrantId;

  logic        Req0_f, Req1_f;
  logic [31:0] Addr0_f, Addr1_f, WData_f;
  logic        Ack0_f, Ack1_f, Err0_f, Err1_f;
  logic [31:0] RData0_f, RData1_f, MemAddress_f, MemWriteData_f, MemReadData_f;
  logic        MemWrite_f, MemRead_f, sh_f, sb_f, lh_f, lb_f, Busy_f, GrantId_f;

  typedef struct {
    bit          port;
    bit          err;
    bit          chk_rd;
    logic [31:0] rd;
  } exp_t;

  exp_t qa[$];
  exp_t qf[$];

  int n_checks = 0;
  int n_errs   = 0;
  int cnt_wr = 0, cnt_rd = 0, cnt_lh = 0, cnt_lb = 0;

  logic [7:0] mem [0:63];
  logic [5:0] ma, ma1, ma2, ma3;

  always #5 Clk = ~Clk;

  dmem_arbiter #(.FIXED_PRIORITY(1'b0), .ADDR_W(32)) dut (
    .Clk(Clk), .Reset(Reset),
    .Req0(Req0), .Req1(Req1), .Wr0(Wr0), .Wr1(Wr1),
    .Size0(Size0), .Size1(Size1), .Addr0(Addr0), .Addr1(Addr1),
    .WData0(WData0), .WData1(WData1),
    .Ack0(Ack0), .Ack1(Ack1), .Err0(Err0), .Err1(Err1),
    .RData0(RData0), .RData1(RData1),
    .MemAddress(MemAddress), .MemWriteData(MemWriteData),
    .MemWrite(MemWrite), .MemRead(MemRead),
    .sh(sh), .sb(sb), .lh(lh), .lb(lb),
    .MemReadData(MemReadData), .Busy(Busy), .GrantId(GrantId)
  );

  dmem_arbiter #(.FIXED_PRIORITY(1'b1), .ADDR_W(32)) dut_f (
    .Clk(Clk), .Reset(Reset),
    .Req0(Req0_f), .Req1(Req1_f), .Wr0(1'b0), .Wr1(1'b0),
    .Size0(2'b00), .Size1(2'b00), .Addr0(Addr0_f), .Addr1(Addr1_f),
    .WData0(WData_f), .WData1(WData_f),
    .Ack0(Ack0_f), .Ack1(Ack1_f), .Err0(Err0_f), .Err1(Err1_f),
    .RData0(RData0_f), .RData1(RData1_f),
    .MemAddress(MemAddress_f), .MemWriteData(MemWriteData_f),
    .MemWrite(MemWrite_f), .MemRead(MemRead_f),
    .sh(sh_f), .sb(sb_f), .lh(lh_f), .lb(lb_f),
    .MemReadData(MemReadData_f), .Busy(Busy_f), .GrantId(GrantId_f)
  );

  // Little-endian DataMemory model with combinational read and sign-extending lb/lh.
  always_comb begin
    ma  = MemAddress[5:0];
    ma1 = 6'(ma + 6'd1);
    ma2 = 6'(ma + 6'd2);
    ma3 = 6'(ma + 6'd3);
    if (lb)
      MemReadData = {{24{mem[ma][7]}}, mem[ma]};
    else if (lh)
      MemReadData = {{16{mem[ma1][7]}}, mem[ma1], mem[ma]};
    else
      MemReadData = {mem[ma3], mem[ma2], mem[ma1], mem[ma]};
  end

  assign MemReadData_f = MemAddress_f ^ 32'hA5A5_0000;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void score(string tag, exp_t e, bit port, bit err, logic [31:0] rd);
    chk({tag, "_port"}, 32'(port), 32'(e.port));
    chk({tag, "_err"}, 32'(err), 32'(e.err));
    if (e.chk_rd) chk({tag, "_rdata"}, rd, e.rd);
  endfunction

  task automatic memory_model();
    forever begin
      @(posedge Clk);
      if (MemWrite) begin
        if (sb) mem[ma] = MemWriteData[7:0];
        else if (sh) begin
          mem[ma] = MemWriteData[7:0];  mem[ma1] = MemWriteData[15:8];
        end else begin
          mem[ma]  = MemWriteData[7:0];   mem[ma1] = MemWriteData[15:8];
          mem[ma2] = MemWriteData[23:16]; mem[ma3] = MemWriteData[31:24];
        end
      end
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge Clk);
      cnt_wr += int'(MemWrite);
      cnt_rd += int'(MemRead);
      cnt_lh += int'(lh);
      cnt_lb += int'(lb);
      if (Ack0 && Ack1) begin
        n_checks++; n_errs++;
        $display("FAIL dual_ack: Ack0=%b Ack1=%b at %0t", Ack0, Ack1, $time);
      end
      if (Ack0 || Ack1) begin
        if (qa.size() == 0) begin
          n_checks++; n_errs++;
          $display("FAIL unexpected_ack: Ack0=%b Ack1=%b with empty queue", Ack0, Ack1);
        end else begin
          e = qa.pop_front();
          score("rr", e, Ack1, Ack1 ? Err1 : Err0, Ack1 ? RData1 : RData0);
          $display("rr ack port=%0d err=%0d rdata=%h", Ack1, Ack1 ? Err1 : Err0,
                   Ack1 ? RData1 : RData0);
        end
      end
      if (Ack0_f && Ack1_f) begin
        n_checks++; n_errs++;
        $display("FAIL fp_dual_ack: both acks at %0t", $time);
      end
      if (Ack0_f || Ack1_f) begin
        if (qf.size() == 0) begin
          n_checks++; n_errs++;
          $display("FAIL fp_unexpected_ack: Ack0=%b Ack1=%b", Ack0_f, Ack1_f);
        end else begin
          e = qf.pop_front();
          score("fp", e, Ack1_f, Ack1_f ? Err1_f : Err0_f, Ack1_f ? RData1_f : RData0_f);
          $display("fp ack port=%0d rdata=%h", Ack1_f, Ack1_f ? RData1_f : RData0_f);
        end
      end
    end
  endtask

  task automatic push_a(bit port, bit err, bit chk_rd, logic [31:0] rd);
    exp_t e;
    e.port = port; e.err = err; e.chk_rd = chk_rd; e.rd = rd;
    qa.push_back(e);
  endtask

  task automatic set0(logic wr, logic [1:0] size, logic [31:0] addr, logic [31:0] wd);
    Wr0 = wr; Size0 = size; Addr0 = addr; WData0 = wd;
  endtask

  task automatic set1(logic wr, logic [1:0] size, logic [31:0] addr, logic [31:0] wd);
    Wr1 = wr; Size1 = size; Addr1 = addr; WData1 = wd;
  endtask

  // Raises the selected requests together and drops each in its Ack cycle.
  task automatic go(bit u0, bit u1, int exp0, int exp1);
    int n = 0, l0 = 0, l1 = 0;
    Req0 = u0; Req1 = u1;
    while ((Req0 || Req1) && n < 40) begin
      @(posedge Clk); #1; n++;
      if (Req0 && Ack0) begin l0 = n; Req0 = 1'b0; end
      if (Req1 && Ack1) begin l1 = n; Req1 = 1'b0; end
    end
    if (Req0 || Req1) begin
      n_checks++; n_errs++;
      $display("FAIL ack_timeout: Req0=%b Req1=%b still pending", Req0, Req1);
      Req0 = 1'b0; Req1 = 1'b0;
    end
    if (u0) chk("latency0", l0, exp0);
    if (u1) chk("latency1", l1, exp1);
  endtask

  task automatic pulse_reset();
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
  endtask

  initial begin
    int w0, r0, h0, b0, n, n0, l1;
    exp_t e;
    for (int i = 0; i < 64; i++) mem[i] = 8'(i);
    Reset = 1'b1;
    Req0 = 0; Req1 = 0;
    set0(0, 2'b00, 0, 0); set1(0, 2'b00, 0, 0);
    Req0_f = 0; Req1_f = 0; Addr0_f = 32'h10; Addr1_f = 32'h20; WData_f = 0;
    fork
      memory_model();
      monitor();
    join_none
    repeat (3) @(posedge Clk);
    #1;
    chk("reset_acks_errs", {28'b0, Ack0, Ack1, Err0, Err1}, 0);
    chk("reset_rdata0", RData0, 0);
    chk("reset_rdata1", RData1, 0);
    chk("reset_memaddr", MemAddress, 0);
    chk("reset_strobes", {25'b0, MemWrite, MemRead, sh, sb, lh, lb, Busy}, 0);
    chk("reset_grant", 32'(GrantId), 0);
    Reset = 1'b0;
    @(posedge Clk); #1;

    // Word store of all-ones at 0, then lb of address 1.
    set0(1, 2'b00, 0, 32'hFFFF_FFFF);
    push_a(0, 0, 0, 0);
    w0 = cnt_wr;
    go(1, 0, 3, 0);
    chk("store_write_cycles", cnt_wr - w0, 1);
    set0(0, 2'b10, 1, 0);
    push_a(0, 0, 1, 32'hFFFF_FFFF);
    b0 = cnt_lb;
    go(1, 0, 3, 0);
    chk("load_lb_cycles", cnt_lb - b0, 1);

    // Tie right after reset: port 0 first, loser served at the next IDLE sample.
    pulse_reset();
    set0(0, 2'b00, 8, 0); set1(0, 2'b00, 12, 0);
    push_a(0, 0, 1, 32'h0B0A_0908);
    push_a(1, 0, 1, 32'h0F0E_0D0C);
    go(1, 1, 3, 6);
    set0(0, 2'b00, 16, 0);
    push_a(0, 0, 1, 32'h1312_1110);
    go(1, 0, 3, 0);
    set0(0, 2'b00, 8, 0);
    push_a(1, 0, 1, 32'h0F0E_0D0C);
    push_a(0, 0, 1, 32'h0B0A_0908);
    go(1, 1, 6, 3);

    // Misaligned half load on port 1.
    set1(0, 2'b01, 3, 0);
    push_a(1, 1, 1, 0);
    r0 = cnt_rd; h0 = cnt_lh;
    go(0, 1, 0, 2);
    chk("err_no_memread", cnt_rd - r0, 0);
    chk("err_no_lh", cnt_lh - h0, 0);

    // Illegal size store, then confirm word 0 untouched.
    set0(1, 2'b11, 0, 32'h0000_0000);
    push_a(0, 1, 1, 0);
    w0 = cnt_wr;
    go(1, 0, 2, 0);
    chk("illegal_no_write", cnt_wr - w0, 0);
    set0(0, 2'b00, 0, 0);
    push_a(0, 0, 1, 32'hFFFF_FFFF);
    go(1, 0, 3, 0);

    // Reset asserted during the ACCESS cycle of a word store.
    set0(1, 2'b00, 4, 32'h1234_5678);
    Req0 = 1'b1;
    @(posedge Clk); #1;
    chk("access_busy", 32'(Busy), 1);
    Reset = 1'b1;
    #1;
    chk("memwrite_gated", 32'(MemWrite), 0);
    @(posedge Clk); #1;
    Reset = 1'b0; Req0 = 1'b0;
    chk("abort_outputs", {26'b0, Ack0, Ack1, Busy, MemWrite, MemRead, GrantId}, 0);
    chk("abort_memaddr", MemAddress, 0);
    repeat (4) @(posedge Clk);
    #1;
    set0(0, 2'b00, 4, 0);
    push_a(0, 0, 1, 32'h0706_0504);
    go(1, 0, 3, 0);

    // Fixed priority: both held high, port 0 keeps winning until it lets go.
    for (int i = 0; i < 3; i++) begin
      e.port = 0; e.err = 0; e.chk_rd = 1; e.rd = 32'hA5A5_0010;
      qf.push_back(e);
    end
    e.port = 1; e.err = 0; e.chk_rd = 1; e.rd = 32'hA5A5_0020;
    qf.push_back(e);
    Req0_f = 1'b1; Req1_f = 1'b1;
    n = 0; n0 = 0; l1 = 0;
    while (Req1_f && n < 60) begin
      @(posedge Clk); #1; n++;
      if (Ack0_f) begin
        n0++;
        if (n0 == 3) Req0_f = 1'b0;
      end
      if (Ack1_f) begin l1 = n; Req1_f = 1'b0; end
    end
    if (Req1_f) begin
      n_checks++; n_errs++;
      $display("FAIL fp_timeout: port 1 never acked, port0 acks=%0d", n0);
      Req0_f = 1'b0; Req1_f = 1'b0;
    end
    chk("fp_port0_acks", n0, 3);
    chk("fp_port1_latency", l1, 12);

    repeat (3) @(posedge Clk);
    #1;
    chk("rr_queue_empty", qa.size(), 0);
    chk("fp_queue_empty", qf.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
